// File: rtl/io_frame_mux_pkg.sv
// Shared constants for the IO frame multiplexer: phase-0 word layout and bank packing.
// Latency: n/a (constants and a constant function only).
// Backpressure: n/a.
//
// Contents: phase-0 bit positions, banks carried per RAM phase, reset pad word,
// and a ceiling-divide helper used to size the number of RAM phases.
package io_frame_mux_pkg;

   localparam int PAD_W           = 8;
   localparam int MARKER_BIT      = 7;
   localparam int ROM_CMD_BIT     = 6;
   localparam int SYNC_BIT        = 5;
   localparam int DATA_EN_BIT     = 4;
   localparam int DATA_LSB        = 0;
   localparam int DATA_FIELD_W    = 4;
   localparam int TEST_PIN        = 4;
   localparam int BANKS_PER_PHASE = 7;

   localparam logic [PAD_W-1:0] RESET_WORD = 8'h80;

   function automatic int ceil_div(input int num, input int den);
      return (num + den - 1) / den;
   endfunction

endpackage

// File: rtl/io_frame_phase_ctr.sv
// Frame phase counter with halt gating; produces cpu_en and the phase-0 strobe.
// Latency: strobes are combinational from the phase register and halt.
// Backpressure: halt freezes the counter and suppresses both strobes.
//
// Ports:
//   clock, reset_n : clock, async active-low reset
//   halt           : freeze the counter while high
//   phase          : current frame phase, 0..FRAME_LEN-1
//   cpu_en         : high in the last phase when not halted
//   phase0_stb     : high in phase 0 when not halted (edge ending phase 0)
module io_frame_phase_ctr
   import io_frame_mux_pkg::*;
#(
   parameter int FRAME_LEN = 2,
   parameter int PH_W      = 1
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            halt,
   output logic [PH_W-1:0] phase,
   output logic            cpu_en,
   output logic            phase0_stb
);

   localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(FRAME_LEN - 1);

   logic last_phase;

   assign last_phase = (phase == LAST_PHASE);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         phase <= '0;
      end else if (!halt) begin
         phase <= last_phase ? '0 : phase + PH_W'(1);
      end
   end

   // A halted last phase does not pulse; the pulse is taken on release.
   assign cpu_en     = last_phase & ~halt;
   assign phase0_stb = (phase == '0) & ~halt;

endmodule

// File: rtl/io_frame_mux.sv
// Time-multiplexes a snapshot of CPU bus outputs onto 8 pads and samples CPU inputs back.
// Latency: CPU outputs captured in the cpu_en cycle appear on pad_out the next cycle (phase 0).
// Backpressure: halt freezes phase, snapshot and input registers; pad_out holds, cpu_en is 0.
//
// Optional feature: define IO_FRAME_MUX_PARITY_EN to append a parity phase carrying the
// XOR of every pad bit sent earlier in the frame; cpu_en then moves to that phase.
//
// Ports:
//   clock, reset_n          : clock, async active-low reset
//   halt                    : freeze framing
//   cpu_data_o, cpu_data_en : CPU data bus out and its drive enable
//   cpu_sync, cpu_rom_cmd   : CPU cycle sync and ROM command
//   cpu_ram_cmd_n           : CPU RAM bank selects, active-low
//   pad_in / pad_out        : chip input pins / multiplexed chip output pins
//   cpu_en                  : CPU clock enable, one pulse per frame
//   cpu_data_i, cpu_test    : registered CPU data-in and test input
module io_frame_mux
   import io_frame_mux_pkg::*;
#(
   parameter int DATA_W    = 4,
   parameter int NUM_BANKS = 4
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 halt,
   input  logic [DATA_W-1:0]    cpu_data_o,
   input  logic                 cpu_data_en,
   input  logic                 cpu_sync,
   input  logic                 cpu_rom_cmd,
   input  logic [NUM_BANKS-1:0] cpu_ram_cmd_n,
   input  logic [PAD_W-1:0]     pad_in,
   output logic [PAD_W-1:0]     pad_out,
   output logic                 cpu_en,
   output logic [DATA_W-1:0]    cpu_data_i,
   output logic                 cpu_test
);

   localparam int RAM_PHASES = ceil_div(NUM_BANKS, BANKS_PER_PHASE);
`ifdef IO_FRAME_MUX_PARITY_EN
   localparam int PAR_PHASES = 1;
`else
   localparam int PAR_PHASES = 0;
`endif
   localparam int FRAME_LEN  = 1 + RAM_PHASES + PAR_PHASES;
   localparam int PH_W       = $clog2(FRAME_LEN);
   localparam int RAM_BITS   = RAM_PHASES * BANKS_PER_PHASE;

   logic [PH_W-1:0] phase;
   logic            phase0_stb;

   // Snapshot of CPU outputs, taken on the cpu_en edge and replayed over the next frame.
   logic [DATA_W-1:0]    snap_data;
   logic                 snap_data_en;
   logic                 snap_sync;
   logic                 snap_rom_cmd;
   logic [NUM_BANKS-1:0] snap_ram_n;

   logic [RAM_BITS-1:0]             ram_pad;
   logic [PAD_W-1:0]                hdr_word;
   logic [FRAME_LEN-1:0][PAD_W-1:0] words;

   // Only the data lanes and the test pin are sampled from the pads.
   logic unused_pad;
   assign unused_pad = &{1'b0, pad_in};

   io_frame_phase_ctr #(
      .FRAME_LEN (FRAME_LEN),
      .PH_W      (PH_W)
   ) u_phase_ctr (
      .clock      (clock),
      .reset_n    (reset_n),
      .halt       (halt),
      .phase      (phase),
      .cpu_en     (cpu_en),
      .phase0_stb (phase0_stb)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         snap_data    <= '0;
         snap_data_en <= 1'b0;
         snap_sync    <= 1'b0;
         snap_rom_cmd <= 1'b0;
         snap_ram_n   <= '1;
      end else if (cpu_en) begin
         snap_data    <= cpu_data_o;
         snap_data_en <= cpu_data_en;
         snap_sync    <= cpu_sync;
         snap_rom_cmd <= cpu_rom_cmd;
         snap_ram_n   <= cpu_ram_cmd_n;
      end
   end

   // The chip drives its answer during phase 0; capture it as that phase ends.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cpu_data_i <= '0;
         cpu_test   <= 1'b0;
      end else if (phase0_stb) begin
         cpu_data_i <= pad_in[DATA_W-1:0];
         cpu_test   <= pad_in[TEST_PIN];
      end
   end

   // Frame words are built purely from the snapshot, so pad_out has no input-to-output path.
   always_comb begin
      // Unused bank slots in the last RAM phase read as deselected (1).
      ram_pad                  = '1;
      ram_pad[NUM_BANKS-1:0]   = snap_ram_n;

      hdr_word                         = '0;
      hdr_word[MARKER_BIT]             = 1'b1;
      hdr_word[ROM_CMD_BIT]            = snap_rom_cmd;
      hdr_word[SYNC_BIT]               = snap_sync;
      hdr_word[DATA_EN_BIT]            = snap_data_en;
      hdr_word[DATA_LSB +: DATA_W]     = snap_data;

      words    = '0;
      words[0] = hdr_word;
      for (int k = 0; k < RAM_PHASES; k++) begin
         words[k+1] = {1'b0, ram_pad[k*BANKS_PER_PHASE +: BANKS_PER_PHASE]};
      end
   end

`ifdef IO_FRAME_MUX_PARITY_EN
   logic                            par_bit;
   logic [FRAME_LEN-1:0][PAD_W-1:0] frame_words;

   always_comb begin
      par_bit = 1'b0;
      for (int k = 0; k < FRAME_LEN - 1; k++) begin
         par_bit = par_bit ^ (^words[k]);
      end
      frame_words                = words;
      frame_words[FRAME_LEN-1]   = {{(PAD_W-1){1'b0}}, par_bit};
   end
`else
   logic [FRAME_LEN-1:0][PAD_W-1:0] frame_words;

   assign frame_words = words;
`endif

   always_comb begin
      pad_out = frame_words[0];
      for (int i = 1; i < FRAME_LEN; i++) begin
         if (phase == PH_W'(i)) begin
            pad_out = frame_words[i];
         end
      end
   end

endmodule

// File: tb/tb_io_frame_mux.sv
// Self-checking bench for io_frame_mux: directed scenarios plus randomized traffic
// compared against a frame-level reference model.
// Latency/backpressure: exercises the one-cycle snapshot-to-pad delay and halt freezing.
module tb_io_frame_mux;

   localparam int DATA_W     = 4;
   localparam int NUM_BANKS  = 4;
   localparam int RAM_PHASES = (NUM_BANKS + 6) / 7;
`ifdef IO_FRAME_MUX_PARITY_EN
   localparam int FL = 2 + RAM_PHASES;
`else
   localparam int FL = 1 + RAM_PHASES;
`endif

   logic                 clock;
   logic                 reset_n;
   logic                 halt;
   logic [DATA_W-1:0]    cpu_data_o;
   logic                 cpu_data_en;
   logic                 cpu_sync;
   logic                 cpu_rom_cmd;
   logic [NUM_BANKS-1:0] cpu_ram_cmd_n;
   logic [7:0]           pad_in;
   logic [7:0]           pad_out;
   logic                 cpu_en;
   logic [DATA_W-1:0]    cpu_data_i;
   logic                 cpu_test;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   int                   m_phase;
   logic [DATA_W-1:0]    m_data;
   logic                 m_den, m_sync, m_rom;
   logic [NUM_BANKS-1:0] m_ram;
   logic [DATA_W-1:0]    m_di;
   logic                 m_test;

   io_frame_mux #(
      .DATA_W    (DATA_W),
      .NUM_BANKS (NUM_BANKS)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .halt          (halt),
      .cpu_data_o    (cpu_data_o),
      .cpu_data_en   (cpu_data_en),
      .cpu_sync      (cpu_sync),
      .cpu_rom_cmd   (cpu_rom_cmd),
      .cpu_ram_cmd_n (cpu_ram_cmd_n),
      .pad_in        (pad_in),
      .pad_out       (pad_out),
      .cpu_en        (cpu_en),
      .cpu_data_i    (cpu_data_i),
      .cpu_test      (cpu_test)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic model_reset();
      m_phase = 0;
      m_data  = '0;
      m_den   = 1'b0;
      m_sync  = 1'b0;
      m_rom   = 1'b0;
      m_ram   = '1;
      m_di    = '0;
      m_test  = 1'b0;
   endtask

   // Expected pad word for a given phase, built from the frame definition.
   function automatic logic [7:0] exp_word(input int ph);
      logic [7:0] frame [FL];
      logic [3:0] d4;
      logic       p;
      int         idx;
      d4       = 4'(m_data);
      frame[0] = {1'b1, m_rom, m_sync, m_den, d4};
      for (int k = 1; k <= RAM_PHASES; k++) begin
         frame[k] = 8'h00;
         for (int b = 0; b < 7; b++) begin
            idx = 7 * (k - 1) + b;
            frame[k][b] = (idx < NUM_BANKS) ? m_ram[idx] : 1'b1;
         end
      end
      if (FL > 1 + RAM_PHASES) begin
         p = 1'b0;
         for (int j = 0; j < FL - 1; j++)
            for (int b = 0; b < 8; b++)
               p = p ^ frame[j][b];
         frame[FL-1] = {7'b0, p};
      end
      return frame[ph];
   endfunction

   task automatic set_idle();
      halt          = 1'b0;
      cpu_data_o    = '0;
      cpu_data_en   = 1'b0;
      cpu_sync      = 1'b0;
      cpu_rom_cmd   = 1'b0;
      cpu_ram_cmd_n = '1;
      pad_in        = 8'h00;
   endtask

   // One clock: advance the model with the inputs present at the edge, then settle.
   task automatic tick();
      @(posedge clock);
      if (!reset_n) begin
         model_reset();
      end else if (!halt) begin
         if (m_phase == FL - 1) begin
            m_data = cpu_data_o;
            m_den  = cpu_data_en;
            m_sync = cpu_sync;
            m_rom  = cpu_rom_cmd;
            m_ram  = cpu_ram_cmd_n;
         end
         if (m_phase == 0) begin
            m_di   = pad_in[DATA_W-1:0];
            m_test = pad_in[4];
         end
         m_phase = (m_phase + 1) % FL;
      end
      #1;
   endtask

   task automatic test_reset();
      int c;
      reset_n = 1'b0;
      set_idle();
      model_reset();
      repeat (3) tick();
      n_cmp++; if (pad_out !== 8'h80) begin n_bad++; $display("FAIL reset_pad: got %h expected 80", pad_out); end
      n_cmp++; if (cpu_en !== 1'b0) begin n_bad++; $display("FAIL reset_cpu_en: got %b expected 0", cpu_en); end
      n_cmp++; if (cpu_data_i !== '0) begin n_bad++; $display("FAIL reset_data_i: got %h expected 0", cpu_data_i); end
      n_cmp++; if (cpu_test !== 1'b0) begin n_bad++; $display("FAIL reset_test: got %b expected 0", cpu_test); end
      reset_n = 1'b1;
      #1;
      n_cmp++; if (pad_out !== 8'h80) begin n_bad++; $display("FAIL release_pad: got %h expected 80", pad_out); end
      c = 0;
      while (cpu_en !== 1'b1 && c < 20) begin
         tick();
         c++;
      end
      n_cmp++; if (c !== FL - 1) begin n_bad++; $display("FAIL first_cpu_en: got cycle %0d expected %0d", c, FL - 1); end
   endtask

   task automatic test_idle();
      logic [7:0] e;
      for (int i = 0; i < 4 * FL; i++) begin
         tick();
         if (m_phase == 0) e = 8'h80;
         else if (m_phase <= RAM_PHASES) e = 8'h7F;
         else e = 8'h00;
         n_cmp++; if (pad_out !== e) begin n_bad++; $display("FAIL idle_pad: got %h expected %h", pad_out, e); end
         n_cmp++; if (cpu_en !== (m_phase == FL - 1)) begin n_bad++; $display("FAIL idle_cpu_en: got %b at phase %0d", cpu_en, m_phase); end
      end
   endtask

   task automatic test_frame_word();
      int c;
      c = 0;
      while (m_phase != FL - 1 && c < 20) begin tick(); c++; end
      cpu_data_o    = 4'hA;
      cpu_data_en   = 1'b1;
      cpu_sync      = 1'b1;
      cpu_rom_cmd   = 1'b0;
      cpu_ram_cmd_n = 4'b1101;
      tick();
      set_idle();
      #1;
      n_cmp++; if (pad_out !== 8'hBA) begin n_bad++; $display("FAIL frame_hdr: got %h expected BA", pad_out); end
      n_cmp++; if (cpu_en !== 1'b0) begin n_bad++; $display("FAIL frame_hdr_en: got %b expected 0", cpu_en); end
      tick();
      n_cmp++; if (pad_out !== 8'h7D) begin n_bad++; $display("FAIL frame_ram: got %h expected 7D", pad_out); end
`ifdef IO_FRAME_MUX_PARITY_EN
      n_cmp++; if (cpu_en !== 1'b0) begin n_bad++; $display("FAIL frame_ram_en: got %b expected 0", cpu_en); end
      tick();
      n_cmp++; if (pad_out !== 8'h01) begin n_bad++; $display("FAIL frame_parity: got %h expected 01", pad_out); end
      n_cmp++; if (cpu_en !== 1'b1) begin n_bad++; $display("FAIL frame_parity_en: got %b expected 1", cpu_en); end
`else
      n_cmp++; if (cpu_en !== 1'b1) begin n_bad++; $display("FAIL frame_ram_en: got %b expected 1", cpu_en); end
`endif
   endtask

   task automatic test_pad_in();
      int c;
      c = 0;
      while (m_phase != 0 && c < 20) begin tick(); c++; end
      pad_in = 8'h1C;
      tick();
      pad_in = 8'h00;
      for (int i = 0; i < FL; i++) begin
         n_cmp++; if (cpu_data_i !== 4'hC) begin n_bad++; $display("FAIL pad_in_data: got %h expected C", cpu_data_i); end
         n_cmp++; if (cpu_test !== 1'b1) begin n_bad++; $display("FAIL pad_in_test: got %b expected 1", cpu_test); end
         tick();
      end
      n_cmp++; if (cpu_data_i !== 4'h0) begin n_bad++; $display("FAIL pad_in_reload: got %h expected 0", cpu_data_i); end
      n_cmp++; if (cpu_test !== 1'b0) begin n_bad++; $display("FAIL pad_in_test_reload: got %b expected 0", cpu_test); end
   endtask

   task automatic test_halt();
      int         c;
      logic [7:0] e;
      c = 0;
      while (m_phase != 1 && c < 20) begin tick(); c++; end
      e = exp_word(1);
      halt = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cpu_data_o = DATA_W'($urandom);
         cpu_ram_cmd_n = NUM_BANKS'($urandom);
         pad_in = 8'($urandom);
         #1;
         n_cmp++; if (pad_out !== e) begin n_bad++; $display("FAIL halt_pad: got %h expected %h", pad_out, e); end
         n_cmp++; if (cpu_en !== 1'b0) begin n_bad++; $display("FAIL halt_cpu_en: got %b expected 0", cpu_en); end
         tick();
      end
      halt = 1'b0;
      #1;
      n_cmp++; if (pad_out !== e) begin n_bad++; $display("FAIL halt_release_pad: got %h expected %h", pad_out, e); end
      n_cmp++; if (cpu_en !== (FL == 2)) begin n_bad++; $display("FAIL halt_release_en: got %b expected %b", cpu_en, FL == 2); end
      n_cmp++; if (m_phase !== 1) begin n_bad++; $display("FAIL halt_model_phase: got %0d expected 1", m_phase); end
      set_idle();
   endtask

   task automatic test_reset_mid_frame();
      int c;
      c = 0;
      cpu_data_o = 4'h5; cpu_data_en = 1'b1; cpu_rom_cmd = 1'b1; cpu_ram_cmd_n = '0;
      while (m_phase != 1 && c < 20) begin tick(); c++; end
      #2;
      reset_n = 1'b0;
      #1;
      n_cmp++; if (pad_out !== 8'h80) begin n_bad++; $display("FAIL mid_reset_pad: got %h expected 80", pad_out); end
      n_cmp++; if (cpu_en !== 1'b0) begin n_bad++; $display("FAIL mid_reset_en: got %b expected 0", cpu_en); end
      set_idle();
      tick();
      reset_n = 1'b1;
      #1;
      c = 0;
      while (cpu_en !== 1'b1 && c < 20) begin
         n_cmp++; if (pad_out !== exp_word(m_phase)) begin n_bad++; $display("FAIL mid_reset_pad_seq: got %h expected %h", pad_out, exp_word(m_phase)); end
         tick();
         c++;
      end
      n_cmp++; if (c !== FL - 1) begin n_bad++; $display("FAIL mid_reset_first_en: got cycle %0d expected %0d", c, FL - 1); end
   endtask

   task automatic test_random();
      logic [7:0] e;
      for (int i = 0; i < 3000; i++) begin
         halt          = ($urandom_range(0, 4) == 0);
         cpu_data_o    = DATA_W'($urandom);
         cpu_data_en   = 1'($urandom);
         cpu_sync      = 1'($urandom);
         cpu_rom_cmd   = 1'($urandom);
         cpu_ram_cmd_n = NUM_BANKS'($urandom);
         pad_in        = 8'($urandom);
         #1;
         e = exp_word(m_phase);
         n_cmp++;
         if (pad_out !== e) begin
            n_bad++;
            if (n_bad < 20) $display("FAIL rand_pad: got %h expected %h phase %0d", pad_out, e, m_phase);
         end
         n_cmp++;
         if (cpu_en !== (m_phase == FL - 1 && !halt)) begin
            n_bad++;
            if (n_bad < 20) $display("FAIL rand_cpu_en: got %b phase %0d halt %b", cpu_en, m_phase, halt);
         end
         n_cmp++;
         if (cpu_data_i !== m_di || cpu_test !== m_test) begin
            n_bad++;
            if (n_bad < 20) $display("FAIL rand_cpu_in: got %h/%b expected %h/%b", cpu_data_i, cpu_test, m_di, m_test);
         end
         tick();
      end
      set_idle();
   endtask

   initial begin
      test_reset();
      test_idle();
      test_frame_word();
      test_pad_in();
      test_halt();
      test_reset_mid_frame();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/io_frame_mux.md
IO_FRAME_MUX -- requirements
Module: io_frame_mux

Interface
REQ-001 Parameter DATA_W, default 4, CPU data-bus width; legal 1..4.
REQ-002 Parameter NUM_BANKS, default 4, number of ram_cmd_n lines; legal 1..14.
REQ-003 Derived RAM_PHASES = ceil(NUM_BANKS/7); FRAME_LEN = 1 + RAM_PHASES (+1 with parity, REQ-030).
REQ-004 clock  input  1  single clock, all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 halt  input  1  freezes framing while high.
REQ-007 cpu_data_o  input  DATA_W  CPU data bus out.
REQ-008 cpu_data_en  input  1  CPU data-bus drive enable.
REQ-009 cpu_sync  input  1  CPU cycle sync.
REQ-010 cpu_rom_cmd  input  1  CPU ROM command.
REQ-011 cpu_ram_cmd_n  input  NUM_BANKS  CPU RAM bank selects, active-low.
REQ-012 pad_in  input  8  chip input pins.
REQ-013 pad_out  output  8  chip output pins, time-multiplexed.
REQ-014 cpu_en  output  1  CPU clock-enable, one pulse per frame.
REQ-015 cpu_data_i  output  DATA_W  registered CPU data-in.
REQ-016 cpu_test  output  1  registered CPU test input.

Function
REQ-017 Phase counter SHALL count 0..FRAME_LEN-1 then wrap to 0, advancing one per clock when halt=0.
REQ-018 cpu_en SHALL be 1 exactly in cycles where phase=FRAME_LEN-1 and halt=0, else 0.
REQ-019 Snapshot registers SHALL load cpu_data_o, cpu_data_en, cpu_sync, cpu_rom_cmd, cpu_ram_cmd_n on each edge where cpu_en=1; otherwise hold.
REQ-020 Phase 0: pad_out = {1 (frame marker), rom_cmd, sync, data_en, data zero-extended to 4 bits} from snapshot.
REQ-021 Ram phase k (1..RAM_PHASES): pad_out[7]=0, pad_out[6:0]=snapshot ram_cmd_n[7(k-1)+6 : 7(k-1)]; bits beyond NUM_BANKS SHALL read 1.
REQ-022 pad_out SHALL be a function of phase and registered state only (no combinational path from any input).
REQ-023 On the edge ending phase 0 (halt=0), cpu_data_i SHALL load pad_in[DATA_W-1:0] and cpu_test SHALL load pad_in[4]; otherwise hold.
REQ-024 Latency: CPU outputs present in a cpu_en cycle SHALL appear on pad_out in the next cycle (phase 0).
REQ-025 halt=1 SHALL freeze phase, snapshot, cpu_data_i, cpu_test; pad_out holds; cpu_en=0; resumes at the same phase when halt falls.
REQ-026 halt asserted in the last phase SHALL suppress that cpu_en pulse and the snapshot load until release.

Reset
REQ-027 reset_n=0 SHALL asynchronously set phase=0, cpu_en=0, cpu_data_i=0, cpu_test=0, snapshot data/data_en/sync/rom_cmd=0, snapshot ram_cmd_n all 1.
REQ-028 During and immediately after reset pad_out SHALL be 0x80.
REQ-029 Reset mid-frame SHALL abandon the frame; first post-reset cpu_en SHALL occur in cycle FRAME_LEN-1 after release.

Configuration
REQ-030 Macro IO_FRAME_MUX_PARITY_EN defined: one extra final phase; pad_out = {7'b0, p}, p = XOR of all pad_out bits over the frame's preceding phases; cpu_en moves to this phase.
REQ-031 Macro undefined: no parity phase, no parity logic, FRAME_LEN = 1 + RAM_PHASES.

Structure
REQ-032 Package io_frame_mux_pkg SHALL hold bit-position constants of the phase-0 word, MARKER_BIT=7, BANKS_PER_PHASE=7, and a ceil-div function for RAM_PHASES.
REQ-033 Sub-module io_frame_phase_ctr SHALL hold the phase counter, halt gating and cpu_en/last-phase/phase-0 strobes.

Verification
REQ-034 Defaults, reset release, no stimulus -> pad_out alternates 0x80, 0x7F; cpu_en high every 2nd cycle.
REQ-035 Defaults, cpu_data_o=0xA, data_en=1, sync=1, rom_cmd=0, ram_cmd_n=4'b1101 in cpu_en cycle -> next two cycles pad_out=0xBA, 0x7D.
REQ-036 NUM_BANKS=8, ram_cmd_n=8'h7F -> frame pad_out[7:0] = 0x80-word, 0x7F, 0x7E; cpu_en in phase 2 only.
REQ-037 pad_in=0x1C during phase 0 then 0x00 -> cpu_data_i=0xC, cpu_test=1, held until next phase-0 end.
REQ-038 halt=1 for 5 cycles starting in phase 1 -> pad_out constant, no cpu_en; after release cpu_en resumes first cycle.
REQ-039 IO_FRAME_MUX_PARITY_EN, defaults, snapshot phase0=0xBA, phase1=0x7D -> phase 2 pad_out=0x01 (XOR of 0xBA^0x7D = 0xC7, 5 ones, odd) with cpu_en=1.
